// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: state encoding and counter sizing shared by the serial frame receiver.
package serial_frame_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} rx_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction
endpackage

// File: rtl/serial_shift_in.sv
// serial_shift_in: serial-in shift-left register with synchronous clear.
module serial_shift_in #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else if (clr) q <= '0;
        else if (shift) q <= {q[WIDTH-2:0], d};
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: MSB-first framed serial receiver with valid/ready output register.
// SERIAL_FRAME_RX_PARITY_EN adds a trailing even-parity bit per frame and drives parity_err.
import serial_frame_pkg::*;

module serial_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame,
    input  logic             sshift,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             parity_err
);
    localparam int CNT_W = cnt_w(WIDTH);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

    rx_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] sr, word;
    logic armed, start, take, last, drop, load, sr_clr, sr_shift;

    serial_shift_in #(.WIDTH(WIDTH)) u_sr (
        .clk(clk), .rst(rst), .clr(sr_clr), .shift(sr_shift), .d(d), .q(sr)
    );

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // The parity bit completes the word but is never shifted into sr.
    assign word = sr;
    assign sr_shift = take & ~last;
    always_ff @(posedge clk or negedge rst)
        if (!rst) parity_err <= 1'b0;
        else if (load) parity_err <= ^{sr, d};
`else
    logic sr_unused;
    assign sr_unused = sr[WIDTH-1];
    assign word = {sr[WIDTH-2:0], d};
    assign sr_shift = take;
    assign parity_err = 1'b0;
`endif

    assign busy = state == SHIFT;

    always_comb begin
        start = frame & armed;
        take = sshift & (state == SHIFT ? frame : state == IDLE ? start : 1'b0);
        last = take & (cnt == LAST);
        drop = last & q_valid & ~q_ready;
        load = last & ~drop;
        sr_clr = state == IDLE & ~start;
        state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
                  state == SHIFT ? (!frame ? IDLE : last ? DONE : SHIFT) :
                                   (!frame ? IDLE : DONE);
        cnt_n = ((state == SHIFT & ~frame) | last) ? '0 : take ? cnt + 1'b1 : cnt;
    end

    // armed blocks a frame already in progress when reset released from being taken as new.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            q         <= load ? word : q;
            q_valid   <= load | (q_valid & ~q_ready);
            frame_err <= state == SHIFT & ~frame & (cnt != '0);
            overrun   <= drop | (overrun & ~clr_ovr);
            armed     <= armed | ~frame;
        end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial-in/parallel-out frame receiver, MSB first.
- Counterpart to the team's parallel-load shift-left serializer: it captures the bit stream that serializer emits.
- Samples `d` on qualified shift strobes inside a `frame` window, counts bits, and presents the assembled word on a valid/ready output register.
- Used on the HWAG configuration/data links between the serial front end and the register block.

Parameters:
- WIDTH, 8, word length in bits. Legal range is WIDTH ≥ 2; the bench must elaborate-check this.
- CNT_W, $clog2(WIDTH+2), bit-counter width. Derived localparam, not overridable.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- frame  in  1  frame window, level, synchronous to clk; high while a word is on the wire.
- sshift  in  1  one-clk sample strobe; `d` is valid on edges where sshift=1.
- d  in  1  serial data.
- q  out  WIDTH  received word.
- q_valid  out  1  q holds an unconsumed word.
- q_ready  in  1  consumer accepts q on an edge where q_valid & q_ready.
- busy  out  1  state==SHIFT.
- frame_err  out  1  one-clk pulse: frame dropped with a partial word.
- overrun  out  1  sticky: a completed word was dropped.
- clr_ovr  in  1  synchronous clear of overrun.
- parity_err  out  1  see Optional Feature.

Behaviour:
- Reset (rst=0, async): state=IDLE, shift reg=0, count=0, q=0, q_valid=0, busy=0, frame_err=0, overrun=0, parity_err=0. Reset mid-frame discards the partial word; the rest of that frame is not recognised as a new frame until frame goes low.
- FSM states:
  - IDLE: frame=1 → SHIFT. If sshift=1 on that same edge, the bit is accepted (count 0→1).
  - SHIFT: each edge with frame=1 & sshift=1 does sr <= {sr[WIDTH-2:0], d}, count++.
  - SHIFT, last bit (count==NBITS-1 & sshift): word completes → DONE. NBITS=WIDTH, or WIDTH+1 with the macro.
  - SHIFT, frame=0 with count>0 → IDLE, frame_err=1 for one clk, count=0.
  - SHIFT, frame=0 with count==0 → IDLE silently.
  - DONE: sshift ignored (surplus bits dropped, no error). frame=0 → IDLE. A new word requires ≥1 clk of frame=0.
- Latency: q and q_valid update on the same edge that samples the last data bit, i.e. q_valid is visible 1 clk after the final strobe.
- Output handshake, on a completion edge:
  - q_valid=0, or q_valid=1 & q_ready=1: q loads the new word, q_valid=1.
  - q_valid=1 & q_ready=0: new word dropped, q unchanged, overrun<=1.
- Output handshake, on a non-completion edge: q_valid & q_ready → q_valid<=0; q holds its value.
- Overrun clear: clr_ovr clears overrun unless a new overrun occurs on the same edge; set wins.
- frame and sshift are assumed already synchronised to clk; no metastability handling in this block.

Optional Feature:
- Macro: SERIAL_FRAME_RX_PARITY_EN.
- Defined:
  - Each frame carries WIDTH data bits plus one trailing even-parity bit.
  - Completion happens on the parity bit. parity_err <= ^{word, pbit} on the completion edge.
  - parity_err is held while q_valid=1 and updates only with q.
  - The word is delivered even when parity fails.
- Undefined: frames are WIDTH bits; the parity_err port remains and is tied 0.

Decomposition:
- Package serial_frame_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} rx_state_t;
  - function cnt_w(width).
- One natural sub-module, serial_shift_in #(WIDTH):
  - Ports: clk, rst (async active-low), clr, shift, d, q.
  - Behaviour: serial-in shift-left register with synchronous clear; instantiated for sr.

Test Plan:
- WIDTH=8; frame high; 8 strobes sending 0xA5 MSB first; q_ready=1 → q=0xA5, q_valid for 1 clk after the handshake edge, frame_err=0, overrun=0.
- Sparse strobes: 3 idle clks between each sshift; send 0x3C → q=0x3C. Assert busy throughout the bits; busy=0 once DONE.
- frame drops after 5 bits → frame_err 1-clk pulse, q_valid stays 0. Next frame with 0xFF → q=0xFF with no stale bits.
- q_ready=0; send 0x11 then 0x22 in separate frames → q=0x11, overrun=1. clr_ovr pulse → overrun=0.
- Reset low after bit 4 of 0x81 → all outputs 0 immediately. Release reset, cycle frame, send 0x81 → q=0x81.
- Macro defined: 0x0F + pbit 0 → parity_err=0; 0x0F + pbit 1 → parity_err=1, q=0x0F. Macro undefined: parity_err always 0.
